tmds_link_sequencer: RTL and testbench



---
 rtl/tmds_pkg.sv | 29 ++
 rtl/video_timing_counter.sv | 63 ++++++
 rtl/tmds_link_sequencer.sv | 132 +++++++++++++
 tb/tb_tmds_link_sequencer.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS link definitions: DVI control tokens, link states, pixel word.
package tmds_pkg;

    localparam logic [9:0] CTL_00    = 10'b1101010100;
    localparam logic [9:0] CTL_01    = 10'b0010101011;
    localparam logic [9:0] CTL_10    = 10'b0101010100;
    localparam logic [9:0] CTL_11    = 10'b1010101011;
    localparam logic [9:0] SYM_BLACK = 10'b0100000000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } link_state_t;

    typedef logic [29:0] pix_word_t;

    function automatic logic [9:0] ctl_token(input logic c1, input logic c0);
        logic [9:0] t;
        case ({c1, c0})
            2'b01:   t = CTL_01;
            2'b10:   t = CTL_10;
            2'b11:   t = CTL_11;
            default: t = CTL_00;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v position counters with active, sync and frame-wrap decode.
module video_timing_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic active,
    output logic hsync_act,
    output logic vsync_act,
    output logic frame_wrap,
    output logic origin
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int HS0     = H_ACTIVE + H_FP;
    localparam int HS1     = HS0 + H_SYNC;
    localparam int VS0     = V_ACTIVE + V_FP;
    localparam int VS1     = VS0 + V_SYNC;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_last;
    logic          v_last;

    assign h_last = int'(h) == H_TOTAL - 1;
    assign v_last = int'(v) == V_TOTAL - 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (clr) begin
            h <= '0;
            v <= '0;
        end else if (en) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    assign active     = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    assign hsync_act  = (int'(h) >= HS0) && (int'(h) < HS1);
    assign vsync_act  = (int'(v) >= VS0) && (int'(v) < VS1);
    assign frame_wrap = h_last && v_last;
    assign origin     = (h == '0) && (v == '0);

endmodule

// File: rtl/tmds_link_sequencer.sv
// Pixel-clock sequencer feeding three TMDS serializers with data or control
// symbols; starts and stops the link only on frame boundaries.
module tmds_link_sequencer
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [29:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [9:0]  sym0,
    output logic [9:0]  sym1,
    output logic [9:0]  sym2,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic        running,
    output logic        underflow,
    input  logic        underflow_clr
);

    link_state_t state;
    link_state_t state_nxt;
    logic        live;
    logic        cnt_clr;
    logic        active;
    logic        hs_act;
    logic        vs_act;
    logic        frame_wrap;
    logic        origin;
    logic        take;
    logic        starve;
    pix_word_t   hold;

    assign cnt_clr = (state == IDLE);

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .en         (live),
        .active     (active),
        .hsync_act  (hs_act),
        .vsync_act  (vs_act),
        .frame_wrap (frame_wrap),
        .origin     (origin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        live      = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                live = 1'b1;
                if (!enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                live = 1'b1;
                if (frame_wrap) state_nxt = enable ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign running   = live;
    assign pix_ready = live & active;
    assign take      = pix_ready & pix_valid;
    assign starve    = pix_ready & ~pix_valid;

    // hold is the fallback for a starved pixel; black until the frame's first word lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym0        <= CTL_00;
            sym1        <= CTL_00;
            sym2        <= CTL_00;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            hold        <= {3{SYM_BLACK}};
        end else begin
            if (take) hold <= pix_data;
            else if (!live || frame_wrap) hold <= {3{SYM_BLACK}};
            underflow   <= starve | (underflow & ~underflow_clr);
            de          <= pix_ready;
            frame_start <= live & origin;
            hsync       <= (live & hs_act) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= (live & vs_act) ? VSYNC_POL : ~VSYNC_POL;
            if (take) begin
                {sym2, sym1, sym0} <= pix_data;
            end else if (pix_ready) begin
                {sym2, sym1, sym0} <= hold;
            end else begin
                sym2 <= CTL_00;
                sym1 <= CTL_00;
                sym0 <= live ? ctl_token(vs_act, hs_act) : CTL_00;
            end
        end
    end

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Randomised bench for tmds_link_sequencer against a frame-position model.
module tb_tmds_link_sequencer;

    localparam int HA  = 4;
    localparam int HFP = 1;
    localparam int HSW = 2;
    localparam int HBP = 1;
    localparam int VA  = 2;
    localparam int VFP = 1;
    localparam int VSW = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] BLK = 10'b0100000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic        underflow_clr = 1'b0;
    logic [29:0] pix_data = '0;
    logic        pix_ready;
    logic [9:0]  sym0;
    logic [9:0]  sym1;
    logic [9:0]  sym2;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;
    logic        running;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    // model: link on/off, stop request, counter position, registered outputs
    bit          m_on;
    bit          m_stop;
    int          m_pos;
    int          m_prev_pos;
    bit          m_took;
    logic [29:0] m_last;
    logic [29:0] e_sym;
    logic        e_hs;
    logic        e_vs;
    logic        e_de;
    logic        e_fs;
    logic        e_uf;
    int          src_n;
    bit          rand_data;

    tmds_link_sequencer #(
        .H_ACTIVE  (HA),
        .H_FP      (HFP),
        .H_SYNC    (HSW),
        .H_BP      (HBP),
        .V_ACTIVE  (VA),
        .V_FP      (VFP),
        .V_SYNC    (VSW),
        .V_BP      (VBP),
        .HSYNC_POL (1'b0),
        .VSYNC_POL (1'b0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .sym0          (sym0),
        .sym1          (sym1),
        .sym2          (sym2),
        .hsync         (hsync),
        .vsync         (vsync),
        .de            (de),
        .frame_start   (frame_start),
        .running       (running),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] tok(input bit vs, input bit hs);
        if (vs && hs) return T11;
        if (vs)       return T10;
        if (hs)       return T01;
        return T00;
    endfunction

    function automatic logic [29:0] word(input int n);
        return {10'(n + 2), 10'(n + 1), 10'(n)};
    endfunction

    function automatic logic [36:0] obs();
        return {sym2, sym1, sym0, hsync, vsync, de, frame_start,
                running, pix_ready, underflow};
    endfunction

    function automatic logic [36:0] expv();
        int h = m_pos % HT;
        int v = m_pos / HT;
        logic rdy = m_on && (h < HA) && (v < VA);
        return {e_sym, e_hs, e_vs, e_de, e_fs, logic'(m_on), rdy, e_uf};
    endfunction

    task automatic model_reset();
        m_on       = 0;
        m_stop     = 0;
        m_pos      = 0;
        m_prev_pos = -1;
        m_last     = {BLK, BLK, BLK};
        e_sym      = {T00, T00, T00};
        e_hs       = 1'b1;
        e_vs       = 1'b1;
        e_de       = 1'b0;
        e_fs       = 1'b0;
        e_uf       = 1'b0;
    endtask

    task automatic model_edge();
        int h = m_pos % HT;
        int v = m_pos / HT;
        bit act = m_on && (h < HA) && (v < VA);
        bit hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
        bit vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
        bit set = 0;
        m_took = 0;
        if (!m_on) begin
            e_sym      = {T00, T00, T00};
            e_hs       = 1'b1;
            e_vs       = 1'b1;
            e_de       = 1'b0;
            e_fs       = 1'b0;
            m_prev_pos = -1;
        end else begin
            e_hs       = !hs;
            e_vs       = !vs;
            e_de       = act;
            e_fs       = (m_pos == 0);
            m_prev_pos = m_pos;
            if (m_pos == 0) m_last = {BLK, BLK, BLK};
            if (act) begin
                if (pix_valid) begin
                    m_last = pix_data;
                    m_took = 1;
                end else begin
                    set = 1;
                end
                e_sym = m_last;
            end else begin
                e_sym = {T00, T00, tok(vs, hs)};
            end
        end
        if (set) e_uf = 1'b1;
        else if (underflow_clr) e_uf = 1'b0;
        if (!m_on) begin
            m_pos = 0;
            if (enable) begin
                m_on   = 1;
                m_stop = 0;
            end
        end else begin
            if (m_pos == FT - 1 && m_stop) begin
                m_on   = enable;
                m_stop = 0;
            end else if (!enable) begin
                m_stop = 1;
            end
            m_pos = (m_pos + 1) % FT;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(negedge clk);
        if (m_took) begin
            src_n++;
            pix_data = rand_data ? 30'($urandom) : word(src_n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", obs(), expv());
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL idle cyc %0d got %h exp %h", i, obs(), expv());
            end
        end
        checks++;
        if ({sym2, sym1, sym0, hsync, vsync, de, pix_ready} !==
            {T00, T00, T00, 4'b1100}) begin
            errors++;
            $display("FAIL idle_values got %h %b%b%b%b", {sym2, sym1, sym0},
                     hsync, vsync, de, pix_ready);
        end
    endtask

    task automatic test_full_frame();
        int fs_cnt = 0;
        int de_cnt = 0;
        int last_fs = -1;
        int n0;
        rand_data = 0;
        src_n = 0;
        pix_data = word(0);
        pix_valid = 1'b1;
        enable = 1'b1;
        n0 = src_n;
        for (int j = 1; j <= 121; j++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL frame cyc %0d got %h exp %h", j, obs(), expv());
            end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (j - last_fs != FT) begin
                        errors++;
                        $display("FAIL frame_period got %0d exp %0d", j - last_fs, FT);
                    end
                end
                last_fs = j;
                fs_cnt++;
            end
            if (de) de_cnt++;
            if (m_prev_pos >= 0) begin
                int h = m_prev_pos % HT;
                int v = m_prev_pos / HT;
                if (v < VA && (h == 5 || h == 6)) begin
                    checks++;
                    if (hsync !== 1'b0) begin
                        errors++;
                        $display("FAIL hsync_win h%0d got %b exp 0", h, hsync);
                    end
                end
                if (v == 3) begin
                    checks++;
                    if (vsync !== 1'b0) begin
                        errors++;
                        $display("FAIL vsync_line h%0d got %b exp 0", h, vsync);
                    end
                end
                if (v == 0 && h == 5) begin
                    checks++;
                    if (sym0 !== T01) begin
                        errors++;
                        $display("FAIL ch0_hs got %b exp %b", sym0, T01);
                    end
                end
                if (v == 3 && h == 4) begin
                    checks++;
                    if (sym0 !== T10) begin
                        errors++;
                        $display("FAIL ch0_vs got %b exp %b", sym0, T10);
                    end
                end
                if (v == 3 && h == 5) begin
                    checks++;
                    if (sym0 !== T11) begin
                        errors++;
                        $display("FAIL ch0_both got %b exp %b", sym0, T11);
                    end
                end
            end
        end
        checks++;
        if (fs_cnt != 3) begin
            errors++;
            $display("FAIL frame_count got %0d exp 3", fs_cnt);
        end
        checks++;
        if (de_cnt != 24) begin
            errors++;
            $display("FAIL de_count got %0d exp 24", de_cnt);
        end
        checks++;
        if (src_n - n0 != 24) begin
            errors++;
            $display("FAIL consumed got %0d exp 24", src_n - n0);
        end
    endtask

    task automatic test_underflow();
        int n = 0;
        logic [29:0] prev;
        rand_data = 1;
        pix_valid = 1'b1;
        while (!(m_on && m_pos == 2) && n < 100) begin
            cyc();
            n++;
        end
        checks++;
        if (!(m_on && m_pos == 2)) begin
            errors++;
            $display("FAIL uf_seek got pos %0d exp 2", m_pos);
        end
        prev = m_last;
        pix_valid = 1'b0;
        cyc();
        pix_valid = 1'b1;
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL uf_vec got %h exp %h", obs(), expv());
        end
        checks++;
        if ({sym2, sym1, sym0, underflow} !== {prev, 1'b1}) begin
            errors++;
            $display("FAIL uf_repeat got %h/%b exp %h/1", {sym2, sym1, sym0},
                     underflow, prev);
        end
        for (int i = 0; i < 45; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL uf_run cyc %0d got %h exp %h", i, obs(), expv());
            end
        end
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_sticky got %b exp 1", underflow);
        end
        underflow_clr = 1'b1;
        cyc();
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_clr got %b exp 0", underflow);
        end
        n = 0;
        while (!((m_pos % HT) < HA && (m_pos / HT) < VA) && n < 50) begin
            cyc();
            n++;
        end
        pix_valid = 1'b0;
        underflow_clr = 1'b1;
        cyc();
        pix_valid = 1'b1;
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b1 || obs() !== expv()) begin
            errors++;
            $display("FAIL uf_set_wins got %b exp 1", underflow);
        end
        underflow_clr = 1'b1;
        cyc();
        underflow_clr = 1'b0;
    endtask

    task automatic test_stop();
        int n = 0;
        int k = 0;
        while (m_pos != 10 && n < 100) begin
            cyc();
            n++;
        end
        enable = 1'b0;
        while (running === 1'b1 && k < 60) begin
            cyc();
            k++;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL drain cyc %0d got %h exp %h", k, obs(), expv());
            end
        end
        checks++;
        if (k != 30) begin
            errors++;
            $display("FAIL drain_len got %0d exp 30", k);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL post_drain cyc %0d got %h exp %h", i, obs(), expv());
            end
        end
        checks++;
        if ({sym2, sym1, sym0, hsync, vsync, de} !== {T00, T00, T00, 3'b110}) begin
            errors++;
            $display("FAIL stop_idle got %h %b%b%b", {sym2, sym1, sym0},
                     hsync, vsync, de);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int low = 0;
        int fs = 0;
        enable = 1'b1;
        while (!(m_on && m_pos == 20) && n < 100) begin
            cyc();
            n++;
        end
        enable = 1'b0;
        repeat (5) cyc();
        enable = 1'b1;
        for (int i = 0; i < 90; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL b2b cyc %0d got %h exp %h", i, obs(), expv());
            end
            if (running !== 1'b1) low++;
            if (frame_start) fs++;
        end
        checks++;
        if (low != 0 || fs != 2) begin
            errors++;
            $display("FAIL b2b_gap got low %0d fs %0d exp low 0 fs 2", low, fs);
        end
    endtask

    task automatic test_random();
        rand_data = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            pix_valid = ($urandom_range(0, 9) != 0);
            underflow_clr = ($urandom_range(0, 19) == 0);
            pix_data = 30'($urandom);
            cyc();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random cyc %0d got %h exp %h", i, obs(), expv());
            end
        end
        underflow_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        int n = 0;
        logic [29:0] fresh;
        enable = 1'b1;
        pix_valid = 1'b1;
        while (!(m_on && m_pos == 3) && n < 200) begin
            cyc();
            n++;
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL async_rst got %h exp %h", obs(), expv());
        end
        @(negedge clk);
        fresh = 30'($urandom);
        pix_data = fresh;
        enable = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL restart cyc %0d got %h exp %h", i, obs(), expv());
            end
        end
        checks++;
        if ({frame_start, sym2, sym1, sym0} !== {1'b1, fresh}) begin
            errors++;
            $display("FAIL restart_first got %b/%h exp 1/%h", frame_start,
                     {sym2, sym1, sym0}, fresh);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_underflow();
        test_stop();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
